// File: rtl/regfile_sequencer.sv
// Sequences one register-file read, an operand/result exchange with execute, and an optional
// writeback. Optional build macro REGFILE_SEQ_ZERO_REG_EN makes register 0 read as zero and ignore writes.
module regfile_sequencer #(
  parameter int unsigned RD_SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_rs1,
  input  logic [3:0]  cmd_rs2,
  input  logic [3:0]  cmd_rd,
  input  logic        cmd_wb,
  output logic        rf_we,
  output logic [3:0]  rf_i1,
  output logic [3:0]  rf_i2,
  output logic [31:0] rf_y,
  input  logic [31:0] rf_x1,
  input  logic [31:0] rf_x2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StOpnd,
    StRes,
    StWbSet,
    StWbStb
  } state_t;

  localparam logic [1:0] LastCnt = 2'(RD_SETTLE - 1);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [3:0]  r_rd;
  logic        r_wb;
  logic        r_cmd_ready;
  logic        r_busy;
  logic        r_rf_we;
  logic [3:0]  r_rf_i1;
  logic [3:0]  r_rf_i2;
  logic [31:0] r_rf_y;
  logic        r_op_valid;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_res_ready;

  logic [31:0] w_x1;
  logic [31:0] w_x2;
  logic        w_we_en;

`ifdef REGFILE_SEQ_ZERO_REG_EN
  // rf_i1/rf_i2 still hold rs1/rs2 during READ, and r_rd holds rd through writeback.
  assign w_x1    = (r_rf_i1 == 4'd0) ? 32'd0 : rf_x1;
  assign w_x2    = (r_rf_i2 == 4'd0) ? 32'd0 : rf_x2;
  assign w_we_en = (r_rd != 4'd0);
`else
  assign w_x1    = rf_x1;
  assign w_x2    = rf_x2;
  assign w_we_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= 2'd0;
      r_rd        <= 4'd0;
      r_wb        <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_i1     <= 4'd0;
      r_rf_i2     <= 4'd0;
      r_rf_y      <= 32'd0;
      r_op_valid  <= 1'b0;
      r_op_a      <= 32'd0;
      r_op_b      <= 32'd0;
      r_res_ready <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cmd_valid && r_cmd_ready) begin
            r_rf_i1     <= cmd_rs1;
            r_rf_i2     <= cmd_rs2;
            r_rd        <= cmd_rd;
            r_wb        <= cmd_wb;
            r_cnt       <= 2'd0;
            r_rf_we     <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= StRead;
          end
        end
        StRead: begin
          if (r_cnt == LastCnt) begin
            r_op_a     <= w_x1;
            r_op_b     <= w_x2;
            r_op_valid <= 1'b1;
            r_state    <= StOpnd;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        StOpnd: begin
          if (op_ready) begin
            r_op_valid <= 1'b0;
            if (r_wb) begin
              r_res_ready <= 1'b1;
              r_state     <= StRes;
            end else begin
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= StIdle;
            end
          end
        end
        StRes: begin
          if (res_valid) begin
            r_res_ready <= 1'b0;
            r_rf_i2     <= r_rd;
            r_rf_y      <= res_data;
            r_state     <= StWbSet;
          end
        end
        StWbSet: begin
          // Address and data settled for a full cycle before the strobe.
          r_rf_we <= w_we_en;
          r_state <= StWbStb;
        end
        StWbStb: begin
          r_rf_we     <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
        default: begin
          r_rf_we     <= 1'b0;
          r_op_valid  <= 1'b0;
          r_res_ready <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign rf_we     = r_rf_we;
  assign rf_i1     = r_rf_i1;
  assign rf_i2     = r_rf_i2;
  assign rf_y      = r_rf_y;
  assign op_valid  = r_op_valid;
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign res_ready = r_res_ready;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer at RD_SETTLE=1; honours
// REGFILE_SEQ_ZERO_REG_EN to pick the register-0 expectations.
module tb_regfile_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_rs1;
  logic [3:0]  cmd_rs2;
  logic [3:0]  cmd_rd;
  logic        cmd_wb;
  logic        rf_we;
  logic [3:0]  rf_i1;
  logic [3:0]  rf_i2;
  logic [31:0] rf_y;
  logic [31:0] rf_x1;
  logic [31:0] rf_x2;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int n_vec;
  int n_err;

`ifdef REGFILE_SEQ_ZERO_REG_EN
  localparam logic [31:0] ExpZeroOpA = 32'h0;
  localparam logic [31:0] ExpZeroWe  = 32'd0;
`else
  localparam logic [31:0] ExpZeroOpA = 32'hDEAD;
  localparam logic [31:0] ExpZeroWe  = 32'd1;
`endif

  regfile_sequencer #(
    .RD_SETTLE(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rs1  (cmd_rs1),
    .cmd_rs2  (cmd_rs2),
    .cmd_rd   (cmd_rd),
    .cmd_wb   (cmd_wb),
    .rf_we    (rf_we),
    .rf_i1    (rf_i1),
    .rf_i2    (rf_i2),
    .rf_y     (rf_y),
    .rf_x1    (rf_x1),
    .rf_x2    (rf_x2),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                     input logic wb);
    cmd_valid = 1'b1;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_rd    = rd;
    cmd_wb    = wb;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rs1   = 4'd0;
    cmd_rs2   = 4'd0;
    cmd_rd    = 4'd0;
    cmd_wb    = 1'b0;
    rf_x1     = 32'h0;
    rf_x2     = 32'h0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    res_data  = 32'h0;
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rf_we",     32'(rf_we),     32'd0);
    chk("rst_op_valid",  32'(op_valid),  32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd0);
    chk("rst_rf_i1",     32'(rf_i1),     32'd0);
    chk("rst_rf_i2",     32'(rf_i2),     32'd0);
    chk("rst_rf_y",      rf_y,           32'h0);
    chk("rst_op_a",      op_a,           32'h0);
    chk("rst_op_b",      op_b,           32'h0);
    rst = 1'b0;

    // Basic writeback transaction, cycle 0 is now.
    cmd(4'd3, 4'd5, 4'd7, 1'b1);
    rf_x1    = 32'h10;
    rf_x2    = 32'h20;
    op_ready = 1'b1;
    step();
    chk("t1_c1_busy",      32'(busy),      32'd1);
    chk("t1_c1_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t1_c1_rf_i1",     32'(rf_i1),     32'd3);
    chk("t1_c1_rf_i2",     32'(rf_i2),     32'd5);
    chk("t1_c1_op_valid",  32'(op_valid),  32'd0);
    chk("t1_c1_rf_we",     32'(rf_we),     32'd0);
    cmd_valid = 1'b0;
    step();
    chk("t1_c2_op_valid", 32'(op_valid), 32'd1);
    chk("t1_c2_op_a",     op_a,          32'h10);
    chk("t1_c2_op_b",     op_b,          32'h20);
    chk("t1_c2_rf_we",    32'(rf_we),    32'd0);
    res_valid = 1'b1;
    res_data  = 32'h30;
    step();
    chk("t1_c3_op_valid",  32'(op_valid),  32'd0);
    chk("t1_c3_res_ready", 32'(res_ready), 32'd1);
    chk("t1_c3_rf_we",     32'(rf_we),     32'd0);
    step();
    res_valid = 1'b0;
    chk("t1_c4_res_ready", 32'(res_ready), 32'd0);
    chk("t1_c4_rf_we",     32'(rf_we),     32'd0);
    chk("t1_c4_rf_i2",     32'(rf_i2),     32'd7);
    chk("t1_c4_rf_y",      rf_y,           32'h30);
    step();
    chk("t1_c5_rf_we", 32'(rf_we), 32'd1);
    chk("t1_c5_rf_i2", 32'(rf_i2), 32'd7);
    chk("t1_c5_rf_y",  rf_y,       32'h30);
    step();
    chk("t1_c6_rf_we",     32'(rf_we),     32'd0);
    chk("t1_c6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t1_c6_busy",      32'(busy),      32'd0);

    // Operand stall: execute holds op_ready low.
    cmd(4'd1, 4'd2, 4'd4, 1'b0);
    rf_x1    = 32'hAAAA;
    rf_x2    = 32'hBBBB;
    op_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t2_c2_op_valid", 32'(op_valid), 32'd1);
    chk("t2_c2_op_a",     op_a,          32'hAAAA);
    rf_x1 = 32'h1111;
    rf_x2 = 32'h2222;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall_op_valid",  32'(op_valid),  32'd1);
      chk("t2_stall_op_a",      op_a,           32'hAAAA);
      chk("t2_stall_op_b",      op_b,           32'hBBBB);
      chk("t2_stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("t2_stall_busy",      32'(busy),      32'd1);
    end
    op_ready = 1'b1;
    step();
    chk("t2_done_op_valid",  32'(op_valid),  32'd0);
    chk("t2_done_res_ready", 32'(res_ready), 32'd0);
    chk("t2_done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t2_done_busy",      32'(busy),      32'd0);

    // Back-to-back wb=0 commands with cmd_valid held high.
    cmd(4'd8, 4'd9, 4'd10, 1'b0);
    rf_x1 = 32'h55;
    rf_x2 = 32'h66;
    step();
    chk("t3_c1_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t3_c1_rf_i1",     32'(rf_i1),     32'd8);
    cmd(4'd6, 4'd2, 4'd1, 1'b0);
    step();
    chk("t3_c2_op_valid",  32'(op_valid),  32'd1);
    chk("t3_c2_op_a",      op_a,           32'h55);
    chk("t3_c2_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t3_c2_rf_we",     32'(rf_we),     32'd0);
    step();
    chk("t3_c3_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t3_c3_op_valid",  32'(op_valid),  32'd0);
    chk("t3_c3_rf_we",     32'(rf_we),     32'd0);
    step();
    cmd_valid = 1'b0;
    chk("t3_c4_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t3_c4_rf_i1",     32'(rf_i1),     32'd6);
    chk("t3_c4_rf_i2",     32'(rf_i2),     32'd2);
    chk("t3_c4_busy",      32'(busy),      32'd1);
    step();
    chk("t3_c5_op_valid", 32'(op_valid), 32'd1);
    step();
    chk("t3_c6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t3_c6_rf_we",     32'(rf_we),     32'd0);

    // Reset during WB_SET; rd aliases rs1.
    cmd(4'd2, 4'd3, 4'd2, 1'b1);
    rf_x1     = 32'h77;
    rf_x2     = 32'h88;
    res_valid = 1'b1;
    res_data  = 32'h99;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t4_c2_op_a", op_a, 32'h77);
    chk("t4_c2_op_b", op_b, 32'h88);
    step();
    chk("t4_c3_res_ready", 32'(res_ready), 32'd1);
    step();
    chk("t4_c4_rf_i2", 32'(rf_i2), 32'd2);
    chk("t4_c4_rf_y",  rf_y,       32'h99);
    chk("t4_c4_rf_we", 32'(rf_we), 32'd0);
    rst       = 1'b1;
    res_valid = 1'b0;
    step();
    chk("t4_rst_rf_we",     32'(rf_we),     32'd0);
    chk("t4_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t4_rst_busy",      32'(busy),      32'd0);
    chk("t4_rst_rf_i2",     32'(rf_i2),     32'd0);
    chk("t4_rst_rf_y",      rf_y,           32'h0);
    chk("t4_rst_op_a",      op_a,           32'h0);
    rst = 1'b0;
    step();
    chk("t4_post_rf_we",     32'(rf_we),     32'd0);
    chk("t4_post_cmd_ready", 32'(cmd_ready), 32'd1);

    // Register 0 as source and destination.
    cmd(4'd0, 4'd5, 4'd0, 1'b1);
    rf_x1     = 32'hDEAD;
    rf_x2     = 32'h42;
    res_valid = 1'b1;
    res_data  = 32'h5A;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t5_c2_op_a", op_a, ExpZeroOpA);
    chk("t5_c2_op_b", op_b, 32'h42);
    step();
    chk("t5_c3_res_ready", 32'(res_ready), 32'd1);
    step();
    res_valid = 1'b0;
    chk("t5_c4_res_ready", 32'(res_ready), 32'd0);
    chk("t5_c4_rf_y",      rf_y,           32'h5A);
    chk("t5_c4_rf_we",     32'(rf_we),     32'd0);
    step();
    chk("t5_c5_rf_we", 32'(rf_we), ExpZeroWe);
    step();
    chk("t5_c6_rf_we",     32'(rf_we),     32'd0);
    chk("t5_c6_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
